// File: rtl/ddr3_app_arbiter.sv
// Two-port arbiter in front of the DDR3 controller native user interface.
// Port 0 is the model-loader write path, port 1 the compute read/write path.
// Round-robin grants with burst tenure; a grant is only handed over once
// all write data and read returns of the previous owner have completed.
module ddr3_app_arbiter #(
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned OUTST_W   = 5,
  parameter int unsigned ADDR_W    = 33,
  parameter int unsigned DATA_W    = 128,
  localparam int unsigned MASK_W   = DATA_W / 8
) (
  input  logic              ui_clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  // requester 0
  input  logic              req0,
  output logic              gnt0,
  input  logic              cmd_en0,
  input  logic [2:0]        cmd0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              wdf_wren0,
  input  logic [DATA_W-1:0] wdf_data0,
  input  logic [MASK_W-1:0] wdf_mask0,
  output logic              rdy0,
  output logic              wdf_rdy0,
  output logic              rd_valid0,
  output logic [DATA_W-1:0] rd_data0,
  // requester 1
  input  logic              req1,
  output logic              gnt1,
  input  logic              cmd_en1,
  input  logic [2:0]        cmd1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              wdf_wren1,
  input  logic [DATA_W-1:0] wdf_data1,
  input  logic [MASK_W-1:0] wdf_mask1,
  output logic              rdy1,
  output logic              wdf_rdy1,
  output logic              rd_valid1,
  output logic [DATA_W-1:0] rd_data1,
  // DDR3 controller side
  input  logic              app_rdy,
  output logic              app_cmd_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_wdf_rdy,
  output logic              app_wdf_wren,
  output logic [DATA_W-1:0] app_wdf_data,
  output logic [MASK_W-1:0] app_wdf_mask,
  input  logic              app_rd_data_valid,
  input  logic [DATA_W-1:0] app_rd_data
);

  localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic signed [7:0]   wr_pend_q, wr_pend_d;
  logic [OUTST_W-1:0]  outst_q, outst_d;

  logic                o_req, o_cmd_en, o_wren;
  logic [2:0]          o_cmd;
  logic [ADDR_W-1:0]   o_addr;
  logic [DATA_W-1:0]   o_wdata;
  logic [MASK_W-1:0]   o_wmask;
  logic                rd_block, own_rdy, own_wdf_rdy, rd_tag;
  logic                cmd_fire, wr_inc, wr_dec, rd_inc, rd_dec;

  // Select the current owner's request-side signals.
  always_comb begin
    o_req    = owner_q ? req1      : req0;
    o_cmd_en = owner_q ? cmd_en1   : cmd_en0;
    o_cmd    = owner_q ? cmd1      : cmd0;
    o_addr   = owner_q ? addr1     : addr0;
    o_wren   = owner_q ? wdf_wren1 : wdf_wren0;
    o_wdata  = owner_q ? wdf_data1 : wdf_data0;
    o_wmask  = owner_q ? wdf_mask1 : wdf_mask0;
    rd_block = (o_cmd == 3'd1) && (outst_q == '1);
  end

  // Drive controller-side strobes and per-port handshakes; all quiet in reset.
  always_comb begin
    app_cmd_en   = 1'b0;
    app_cmd      = '0;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    own_rdy      = 1'b0;
    own_wdf_rdy  = 1'b0;
    rd_tag       = last_q;
    rdy0         = 1'b0;
    rdy1         = 1'b0;
    wdf_rdy0     = 1'b0;
    wdf_rdy1     = 1'b0;
    rd_valid0    = 1'b0;
    rd_valid1    = 1'b0;
    if (!rst) begin
      app_cmd      = o_cmd;
      app_addr     = o_addr;
      app_wdf_data = o_wdata;
      app_wdf_mask = o_wmask;
      case (state_q)
        S_OWN: begin
          app_cmd_en   = o_cmd_en & ~rd_block;
          app_wdf_wren = o_wren;
          own_rdy      = app_rdy & ~rd_block;
          own_wdf_rdy  = app_wdf_rdy;
          rd_tag       = owner_q;
        end
        // write data of the released owner still flows while draining
        S_DRAIN: begin
          app_wdf_wren = o_wren;
          own_wdf_rdy  = app_wdf_rdy;
          rd_tag       = owner_q;
        end
        default: ;
      endcase
      rdy0      = own_rdy & ~owner_q;
      rdy1      = own_rdy & owner_q;
      wdf_rdy0  = own_wdf_rdy & ~owner_q;
      wdf_rdy1  = own_wdf_rdy & owner_q;
      rd_valid0 = app_rd_data_valid & ~rd_tag;
      rd_valid1 = app_rd_data_valid & rd_tag;
    end
  end

  // Grants decode from registered state; read data is broadcast.
  always_comb begin
    gnt0     = (state_q == S_OWN) & ~owner_q;
    gnt1     = (state_q == S_OWN) & owner_q;
    rd_data0 = app_rd_data;
    rd_data1 = app_rd_data;
  end

  // Outstanding-work accounting and arbitration next-state.
  always_comb begin
    cmd_fire  = app_cmd_en & app_rdy;
    wr_inc    = cmd_fire & (o_cmd == 3'd0);
    wr_dec    = app_wdf_wren & app_wdf_rdy;
    rd_inc    = cmd_fire & (o_cmd == 3'd1);
    rd_dec    = app_rd_data_valid;

    wr_pend_d = wr_pend_q;
    if (wr_inc && !wr_dec)      wr_pend_d = wr_pend_q + 8'sd1;
    else if (!wr_inc && wr_dec) wr_pend_d = wr_pend_q - 8'sd1;

    outst_d = outst_q;
    if (rd_inc && !rd_dec)      outst_d = outst_q + 1'b1;
    else if (!rd_inc && rd_dec) outst_d = outst_q - 1'b1;

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: begin
        if (init_calib_complete && (req0 || req1)) begin
          state_d = S_OWN;
          burst_d = '0;
          owner_d = (req0 && req1) ? ~last_q : req1;
        end
      end
      S_OWN: begin
        if (cmd_fire) burst_d = burst_q + 1'b1;
        // post-edge counts decide, so a final accept/return in this cycle counts
        if (!o_req || (cmd_fire && burst_q == BURST_W'(MAX_BURST - 1))) begin
          last_d  = owner_q;
          state_d = (wr_pend_d == 8'sd0 && outst_d == '0) ? S_GAP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wr_pend_d == 8'sd0 && outst_d == '0) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge ui_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      burst_q   <= '0;
      wr_pend_q <= '0;
      outst_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      burst_q   <= burst_d;
      wr_pend_q <= wr_pend_d;
      outst_q   <= outst_d;
    end
  end

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Self-checking bench for ddr3_app_arbiter, built with a small burst limit and
// outstanding-read depth so tenure and blocking boundaries are reachable.
module tb_ddr3_app_arbiter;

  localparam int MAXB = 4;
  localparam int OW   = 2;
  localparam int OMAX = 3;
  localparam int AW   = 33;
  localparam int DW   = 128;
  localparam int MW   = 16;

  logic ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  logic          rst, calib;
  logic          req [2];
  logic          cmd_en [2];
  logic [2:0]    cmd [2];
  logic [AW-1:0] addr [2];
  logic          wren [2];
  logic [DW-1:0] wdata [2];
  logic [MW-1:0] wmask [2];
  logic          app_rdy, app_wdf_rdy, rdv;
  logic [DW-1:0] rdata;

  logic          gnt0, gnt1, rdy0, rdy1, wdf_rdy0, wdf_rdy1, rd_valid0, rd_valid1;
  logic [DW-1:0] rd_data0, rd_data1, app_wdf_data;
  logic          app_cmd_en, app_wdf_wren;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic [MW-1:0] app_wdf_mask;

  ddr3_app_arbiter #(.MAX_BURST(MAXB), .OUTST_W(OW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ui_clk(ui_clk), .rst(rst), .init_calib_complete(calib),
    .req0(req[0]), .gnt0(gnt0), .cmd_en0(cmd_en[0]), .cmd0(cmd[0]), .addr0(addr[0]),
    .wdf_wren0(wren[0]), .wdf_data0(wdata[0]), .wdf_mask0(wmask[0]),
    .rdy0(rdy0), .wdf_rdy0(wdf_rdy0), .rd_valid0(rd_valid0), .rd_data0(rd_data0),
    .req1(req[1]), .gnt1(gnt1), .cmd_en1(cmd_en[1]), .cmd1(cmd[1]), .addr1(addr[1]),
    .wdf_wren1(wren[1]), .wdf_data1(wdata[1]), .wdf_mask1(wmask[1]),
    .rdy1(rdy1), .wdf_rdy1(wdf_rdy1), .rd_valid1(rd_valid1), .rd_data1(rd_data1),
    .app_rdy(app_rdy), .app_cmd_en(app_cmd_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_rd_data_valid(rdv), .app_rd_data(rdata)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  string tname;

  // Reference model: who holds the interface, whether the previous holder is
  // still finishing, the one-cycle gap, and a queue naming the port of each
  // read still in flight (returns come back in order).
  bit m_gr, m_dr, m_gap;
  int m_own, m_last, m_burst, m_wp;
  int m_q[$];

  // {gnt0,gnt1,app_cmd_en,app_wdf_wren,rdy0,rdy1,wdf_rdy0,wdf_rdy1,rd_valid0,rd_valid1}
  function automatic logic [9:0] act_outs();
    return {gnt0, gnt1, app_cmd_en, app_wdf_wren, rdy0, rdy1, wdf_rdy0, wdf_rdy1, rd_valid0, rd_valid1};
  endfunction

  function automatic logic [9:0] model_outs();
    logic [9:0] e;
    bit act, blk;
    int p;
    e = '0;
    e[9] = m_gr && m_own == 0;
    e[8] = m_gr && m_own == 1;
    if (rst) return e;
    act = m_gr || m_dr;
    blk = m_gr && cmd[m_own] == 3'd1 && m_q.size() == OMAX;
    e[7] = m_gr && cmd_en[m_own] && !blk;
    e[6] = act && wren[m_own];
    if (m_gr && app_rdy && !blk) e[5 - m_own] = 1'b1;
    if (act && app_wdf_rdy) e[3 - m_own] = 1'b1;
    if (rdv) begin
      p = (m_q.size() > 0) ? m_q[0] : (act ? m_own : m_last);
      e[1 - p] = 1'b1;
    end
    return e;
  endfunction

  function automatic void model_edge();
    logic [9:0] e;
    bit acc;
    int o;
    if (rst) begin
      m_gr = 0; m_dr = 0; m_gap = 0; m_own = 0; m_last = 1;
      m_burst = 0; m_wp = 0; m_q.delete();
      return;
    end
    e   = model_outs();
    o   = m_own;
    acc = e[7] && app_rdy;
    if (acc && cmd[o] == 3'd0) m_wp++;
    if (e[6] && app_wdf_rdy) m_wp--;
    if (rdv && m_q.size() > 0) void'(m_q.pop_front());
    if (acc && cmd[o] == 3'd1) m_q.push_back(o);
    if (m_gr) begin
      if (acc) m_burst++;
      if (!req[o] || (acc && m_burst == MAXB)) begin
        m_gr = 0; m_last = o;
        if (m_wp == 0 && m_q.size() == 0) m_gap = 1; else m_dr = 1;
      end
    end else if (m_dr) begin
      if (m_wp == 0 && m_q.size() == 0) begin m_dr = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (calib && (req[0] || req[1])) begin
      m_own = (req[0] && req[1]) ? 1 - m_last : (req[0] ? 0 : 1);
      m_gr = 1; m_burst = 0;
    end
  endfunction

  function automatic logic coin(int unsigned pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic tick();
    @(posedge ui_clk);
    model_edge();
    #1;
  endtask

  task automatic quiet_ports();
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; cmd_en[p] = 0; cmd[p] = '0; wren[p] = 0;
      addr[p] = '0; wdata[p] = '0; wmask[p] = '0;
    end
    rdv = 0;
  endtask

  // Drive idle requesters and retire whatever is still in flight.
  task automatic settle(input int n);
    quiet_ports();
    for (int i = 0; i < n; i++) begin
      rdv = m_q.size() > 0;
      wren[0] = m_wp > 0; wren[1] = m_wp > 0;
      app_wdf_rdy = 1;
      tick();
    end
    quiet_ports();
  endtask

  task automatic do_reset();
    quiet_ports();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    tname = "reset";
    rst = 1; calib = 1; req[0] = 1; cmd_en[0] = 1; app_rdy = 1; app_wdf_rdy = 1; rdv = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #1; n_cmp++;
      if (act_outs() !== 10'b0) begin n_bad++; $display("FAIL reset_quiet: got %b want %b", act_outs(), 10'b0); end
      tick();
    end
    rst = 0; cmd_en[0] = 0; rdv = 0; calib = 0;
    tname = "calib_gate";
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if (act_outs() !== model_outs() || gnt0 !== 1'b0) begin
        n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs());
      end
      tick();
    end
  endtask

  task automatic test_single_writes();
    int pulses;
    tname = "single_writes";
    pulses = 0;
    calib = 1;
    #1; n_cmp++;
    if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
    tick();
    n_cmp++;
    if (gnt0 !== 1'b1) begin n_bad++; $display("FAIL gnt0_latency: got %b want 1", gnt0); end
    for (int i = 0; i < 3; i++) begin
      cmd_en[0] = 1; cmd[0] = 3'd0; addr[0] = AW'({$urandom(), $urandom()}); wren[0] = 1;
      #1; n_cmp++;
      if (act_outs() !== model_outs() || app_addr !== addr[0] || app_cmd !== 3'd0) begin
        n_bad++; $display("FAIL %s: got %b/%h want %b/%h", tname, act_outs(), app_addr, model_outs(), addr[0]);
      end
      if (app_cmd_en) pulses++;
      tick();
    end
    cmd_en[0] = 0; wren[0] = 0; req[0] = 0;
    #1; n_cmp++;
    if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
    tick();
    n_cmp++;
    if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL gnt0_release: got %b want 0", gnt0); end
    n_cmp++;
    if (pulses != 3) begin n_bad++; $display("FAIL write_pulses: got %0d want 3", pulses); end
    for (int i = 0; i < 2; i++) begin
      #1; n_cmp++;
      if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
      tick();
    end
  endtask

  task automatic test_contention();
    int k;
    tname = "contention";
    do_reset();
    req[0] = 1; req[1] = 1;
    tick();
    n_cmp++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_bad++; $display("FAIL first_winner: got %b%b want 10", gnt0, gnt1); end
    tick();
    req[0] = 0;
    #1; n_cmp++;
    if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
    tick();
    k = 0;
    while (!gnt1 && k < 10) begin
      #1; n_cmp++;
      if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
      tick(); k++;
    end
    n_cmp++;
    if (k != 2) begin n_bad++; $display("FAIL handover_gap: got %0d cycles want 2", k); end
    req[1] = 0; req[0] = 1;
    tick();
    req[1] = 1;
    #1; n_cmp++;
    if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
    tick(); tick();
    n_cmp++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_bad++; $display("FAIL rr_second: got %b%b want 10", gnt0, gnt1); end
    settle(4);
  endtask

  task automatic test_burst_release();
    int k, acc, rv0;
    bit fire4;
    tname = "burst_release";
    do_reset();
    app_rdy = 1; req[0] = 1; req[1] = 1; cmd_en[0] = 1; cmd[0] = 3'd1;
    k = 0; acc = 0; rv0 = 0;
    while (!gnt1 && k < 40) begin
      rdv = (m_q.size() >= 2) || (!m_gr && m_q.size() > 0);
      rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1; n_cmp++;
      if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
      if (app_cmd_en && app_rdy) acc++;
      if (rd_valid0) rv0++;
      fire4 = app_cmd_en && app_rdy && acc == MAXB;
      tick(); k++;
      if (fire4) begin
        n_cmp++;
        if (gnt0 !== 1'b0) begin n_bad++; $display("FAIL burst_cut: got gnt0=%b want 0", gnt0); end
      end
    end
    n_cmp++;
    if (gnt1 !== 1'b1 || acc != MAXB || rv0 != MAXB) begin
      n_bad++; $display("FAIL burst_totals: got gnt1=%b acc=%0d rv0=%0d want 1/%0d/%0d", gnt1, acc, rv0, MAXB, MAXB);
    end
    settle(6);
  endtask

  task automatic test_rd_block();
    int acc, rv0, k;
    tname = "rd_block";
    do_reset();
    app_rdy = 1; req[0] = 1; cmd_en[0] = 1; cmd[0] = 3'd1;
    tick();
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      #1; n_cmp++;
      if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
      if (app_cmd_en && app_rdy) acc++;
      tick();
    end
    n_cmp++;
    if (acc != OMAX || rdy0 !== 1'b0 || app_cmd_en !== 1'b0) begin
      n_bad++; $display("FAIL rd_limit: got acc=%0d rdy0=%b en=%b want %0d/0/0", acc, rdy0, app_cmd_en, OMAX);
    end
    rdv = 1;
    #1; n_cmp++;
    if (rd_valid0 !== 1'b1 || app_cmd_en !== 1'b0) begin
      n_bad++; $display("FAIL rd_return: got rv0=%b en=%b want 1/0", rd_valid0, app_cmd_en);
    end
    tick();
    rdv = 0;
    #1; n_cmp++;
    if (app_cmd_en !== 1'b1 || rdy0 !== 1'b1) begin
      n_bad++; $display("FAIL rd_unblock: got en=%b rdy0=%b want 1/1", app_cmd_en, rdy0);
    end
    tick();
    cmd_en[0] = 0;
    k = 0; rv0 = 0;
    while (!gnt0 && k < 20) begin
      rdv = m_q.size() > 0;
      #1; n_cmp++;
      if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
      if (rd_valid0) rv0++;
      tick(); k++;
    end
    n_cmp++;
    if (rv0 != OMAX || gnt0 !== 1'b1) begin n_bad++; $display("FAIL rd_drain: got rv0=%0d gnt0=%b want %0d/1", rv0, gnt0, OMAX); end
    settle(4);
  endtask

  task automatic test_write_drain();
    tname = "write_drain";
    do_reset();
    app_rdy = 1; app_wdf_rdy = 1; req[0] = 1;
    tick();
    cmd_en[0] = 1; cmd[0] = 3'd0; addr[0] = AW'($urandom());
    #1; n_cmp++;
    if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
    tick();
    cmd_en[0] = 0; req[0] = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      wren[0] = (i == 2);
      wdata[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
      wmask[0] = MW'($urandom());
      #1; n_cmp++;
      if (act_outs() !== model_outs() || gnt0 !== 1'b0) begin
        n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs());
      end
      if (i == 2) begin
        n_cmp++;
        if (app_wdf_wren !== 1'b1 || app_wdf_data !== wdata[0] || app_wdf_mask !== wmask[0] || wdf_rdy0 !== 1'b1) begin
          n_bad++; $display("FAIL drain_wdata: got wren=%b rdy=%b want 1/1", app_wdf_wren, wdf_rdy0);
        end
      end
      tick();
    end
    wren[0] = 0; req[1] = 1;
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
      tick();
    end
    n_cmp++;
    if (gnt1 !== 1'b1) begin n_bad++; $display("FAIL drain_to_gap: got gnt1=%b want 1", gnt1); end
    settle(4);
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid";
    do_reset();
    app_rdy = 1; req[0] = 1;
    tick();
    cmd_en[0] = 1; cmd[0] = 3'd1;
    tick(); tick();
    rst = 1; req[1] = 1;
    #1; n_cmp++;
    if (act_outs() !== model_outs()) begin n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs()); end
    tick();
    n_cmp++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || app_cmd_en !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got %b%b en=%b want 00 en=0", gnt0, gnt1, app_cmd_en);
    end
    rst = 0;
    tick();
    n_cmp++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_bad++; $display("FAIL post_reset_winner: got %b%b want 10", gnt0, gnt1); end
    for (int i = 0; i < 3; i++) begin
      #1; n_cmp++;
      if (act_outs() !== model_outs() || app_cmd_en !== 1'b1) begin
        n_bad++; $display("FAIL %s: got %b want %b", tname, act_outs(), model_outs());
      end
      tick();
    end
    settle(8);
  endtask

  task automatic test_random();
    logic [9:0] e;
    tname = "random";
    do_reset();
    for (int i = 0; i < 500; i++) begin
      calib = coin(85);
      for (int p = 0; p < 2; p++) begin
        if (coin(10)) req[p] = ~req[p];
        cmd_en[p] = coin(60);
        cmd[p]    = coin(50) ? 3'd1 : 3'd0;
        addr[p]   = AW'({$urandom(), $urandom()});
        wren[p]   = coin(50) && m_wp > 0;
        wdata[p]  = {$urandom(), $urandom(), $urandom(), $urandom()};
        wmask[p]  = MW'($urandom());
      end
      app_rdy     = coin(75);
      app_wdf_rdy = coin(75);
      rdv         = m_q.size() > 0 && coin(40);
      rdata       = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      e = model_outs();
      n_cmp++;
      if (act_outs() !== e) begin n_bad++; $display("FAIL %s[%0d]: got %b want %b", tname, i, act_outs(), e); end
      if (e[7]) begin
        n_cmp++;
        if (app_cmd !== cmd[m_own] || app_addr !== addr[m_own]) begin
          n_bad++; $display("FAIL cmd_mux[%0d]: got %0d/%h want %0d/%h", i, app_cmd, app_addr, cmd[m_own], addr[m_own]);
        end
      end
      if (e[6]) begin
        n_cmp++;
        if (app_wdf_data !== wdata[m_own] || app_wdf_mask !== wmask[m_own]) begin
          n_bad++; $display("FAIL wdf_mux[%0d]: got mask %h want %h", i, app_wdf_mask, wmask[m_own]);
        end
      end
      if (rdv) begin
        n_cmp++;
        if (rd_data0 !== rdata || rd_data1 !== rdata) begin
          n_bad++; $display("FAIL rd_bcast[%0d]: got %h/%h want %h", i, rd_data0, rd_data1, rdata);
        end
      end
      tick();
    end
    settle(20);
  endtask

  initial begin
    rst = 1; calib = 0; app_rdy = 0; app_wdf_rdy = 0; rdata = '0;
    quiet_ports();
    test_reset();
    test_single_writes();
    test_contention();
    test_burst_release();
    test_rd_block();
    test_write_drain();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
